// File: rtl/alu_issue_ctrl.sv
// Issue controller for the R-type ALU: accepts one decoded instruction, holds the
// ALU inputs for the operation latency, then offers the captured completion.
module alu_issue_ctrl #(
  parameter int ALU_LAT    = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_wen,
  output logic        illegal
);

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam int MAX_LAT = (DIV_CYCLES > ALU_LAT) ? DIV_CYCLES : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [31:0]       opA, opANext, opB, opBNext;
  logic [31:0]       resDataQ, resDataNext;
  logic [5:0]        fn, fnNext;
  logic [4:0]        rdQ, rdNext;
  logic              wenQ, wenNext;
  logic              illegalQ, illegalNext;
  logic [5:0]        opcode, funct;
  logic              aluActive;
  logic              unusedInstrBits;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign unusedInstrBits = ^instr[25:16];

  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] f);
    if (op != 6'b000000) return 1'b0;
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_SLL, FN_DIVU, FN_MFHI, FN_MFLO: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opA      <= '0;
      opB      <= '0;
      fn       <= FN_ADD;
      resDataQ <= '0;
      rdQ      <= '0;
      wenQ     <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      opA      <= opANext;
      opB      <= opBNext;
      fn       <= fnNext;
      resDataQ <= resDataNext;
      rdQ      <= rdNext;
      wenQ     <= wenNext;
      illegalQ <= illegalNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    opANext     = opA;
    opBNext     = opB;
    fnNext      = fn;
    resDataNext = resDataQ;
    rdNext      = rdQ;
    wenNext     = wenQ;
    illegalNext = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          rdNext      = instr[15:11];
          fnNext      = funct;
          wenNext     = 1'b0;
          resDataNext = '0;
          if (funct == FN_SLL) begin
            opANext = rt_data;
            opBNext = {27'b0, instr[10:6]};
          end else if (funct == FN_MFHI || funct == FN_MFLO) begin
            opANext = '0;
            opBNext = '0;
          end else begin
            opANext = rs_data;
            opBNext = rt_data;
          end
          if (!isLegal(opcode, funct)) begin
            // Illegal words never reach the ALU; completion carries no writeback.
            illegalNext = 1'b1;
            opANext     = '0;
            opBNext     = '0;
            fnNext      = FN_ADD;
            stateNext   = RESP;
          end else if (funct == FN_DIVU) begin
            cntNext   = CNT_W'(DIV_CYCLES - 1);
            stateNext = DIV;
          end else begin
            cntNext   = CNT_W'(ALU_LAT - 1);
            stateNext = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          resDataNext = alu_result;
          wenNext     = 1'b1;
          stateNext   = RESP;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      DIV: begin
        // HI/LO stay inside the ALU; DIVU completes without a GPR write.
        if (cnt == '0) begin
          resDataNext = '0;
          wenNext     = 1'b0;
          stateNext   = RESP;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      RESP: begin
        if (res_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outside EXEC/DIV the ALU sees a harmless ADD of zeros, so DIVU never leaks.
  assign aluActive   = (state == EXEC) || (state == DIV);
  assign alu_dataA   = aluActive ? opA : 32'd0;
  assign alu_dataB   = aluActive ? opB : 32'd0;
  assign alu_signal  = aluActive ? fn  : FN_ADD;

  assign instr_ready = reset && (state == IDLE);
  assign res_valid   = (state == RESP);
  assign res_data    = resDataQ;
  assign res_rd      = rdQ;
  assign res_wen     = wenQ;
  assign illegal     = illegalQ;

endmodule
